// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table harness: sweeps every minterm into a combinational function,
// captures y after LAT cycles, counts the onset and streams the packed table out.
module tt_sweep_capture #(
    parameter int N_IN   = 8,
    parameter int WORD_W = 32,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   x_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] tt_word,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic              tt_last,
    output logic [N_IN:0]     ones_cnt
);
    localparam int N_MIN   = 1 << N_IN;
    localparam int N_WORDS = N_MIN / WORD_W;
    localparam int K_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int D_W     = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_WORDS - 1);

    typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, STREAM, FIN} state_t;

    state_t             state_reg, state_next;
    logic [N_IN-1:0]    x_reg;
    logic [K_W-1:0]     k_reg;
    logic [D_W-1:0]     drain_reg;
    logic [N_IN:0]      ones_reg;
    logic [N_MIN-1:0]   table_reg;
    logic               cap_valid;
    logic [N_IN-1:0]    cap_idx;
    logic               xfer;

    // Capture point: either the live minterm or the minterm LAT cycles old.
    generate
        if (LAT == 0) begin : g_direct
            assign cap_valid = (state_reg == SWEEP);
            assign cap_idx   = x_reg;
        end else begin : g_pipe
            logic            pv_reg   [LAT];
            logic [N_IN-1:0] pidx_reg [LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        pv_reg[i]   <= 1'b0;
                        pidx_reg[i] <= '0;
                    end
                end else begin
                    pv_reg[0]   <= (state_reg == SWEEP);
                    pidx_reg[0] <= x_reg;
                    for (int i = 1; i < LAT; i++) begin
                        pv_reg[i]   <= pv_reg[i-1];
                        pidx_reg[i] <= pidx_reg[i-1];
                    end
                end
            end
            assign cap_valid = pv_reg[LAT-1];
            assign cap_idx   = pidx_reg[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            k_reg     <= '0;
            drain_reg <= '0;
            ones_reg  <= '0;
            table_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg    <= '0;
                        k_reg    <= '0;
                        ones_reg <= '0;
                    end
                end
                SWEEP: begin
                    if (x_reg != '1) x_reg <= x_reg + 1'b1;
                    drain_reg <= '0;
                end
                DRAIN:  drain_reg <= drain_reg + 1'b1;
                STREAM: if (xfer && k_reg != K_LAST) k_reg <= k_reg + 1'b1;
                default: ;
            endcase
            if (cap_valid) begin
                table_reg[cap_idx] <= y_in;
                if (y_in) ones_reg <= ones_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        xfer       = (state_reg == STREAM) && tt_ready;
        busy       = 1'b0;
        done       = 1'b0;
        tt_valid   = 1'b0;
        tt_last    = 1'b0;
        tt_word    = '0;
        case (state_reg)
            IDLE:  if (start) state_next = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (x_reg == '1) state_next = (LAT == 0) ? STREAM : DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_reg == D_W'(LAT - 1)) state_next = STREAM;
            end
            STREAM: begin
                busy     = 1'b1;
                tt_valid = 1'b1;
                tt_last  = (k_reg == K_LAST);
                tt_word  = table_reg[k_reg*WORD_W +: WORD_W];
                if (xfer && k_reg == K_LAST) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign x_out    = x_reg;
    assign ones_cnt = ones_reg;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: one LAT=0 instance driven by selectable functions,
// one LAT=2 instance behind a 2-stage registered x7 function.
module tb_tt_sweep_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    int          sel = 0;
    int          fsel = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [7:0]  x0, x2;
    logic        y0, y2, busy0, busy2, done0, done2;
    logic        valid0, valid2, last0, last2;
    logic [31:0] word0, word2;
    logic [8:0]  ones0, ones2;
    logic        r1, r2;

    always #5 clk = ~clk;

    assign y0 = (fsel == 0) ? 1'b0 : (fsel == 1) ? x0[0] : (x0 == 8'hFF);
    always @(posedge clk) begin
        r1 <= x2[7];
        r2 <= r1;
    end
    assign y2 = r2;

    tt_sweep_capture #(.N_IN(8), .WORD_W(32), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .x_out(x0), .y_in(y0),
        .busy(busy0), .done(done0), .tt_word(word0), .tt_valid(valid0),
        .tt_ready(ready), .tt_last(last0), .ones_cnt(ones0)
    );

    tt_sweep_capture #(.N_IN(8), .WORD_W(32), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .x_out(x2), .y_in(y2),
        .busy(busy2), .done(done2), .tt_word(word2), .tt_valid(valid2),
        .tt_ready(ready), .tt_last(last2), .ones_cnt(ones2)
    );

    wire [7:0]  o_x     = (sel == 0) ? x0 : x2;
    wire        o_busy  = (sel == 0) ? busy0 : busy2;
    wire        o_done  = (sel == 0) ? done0 : done2;
    wire        o_valid = (sel == 0) ? valid0 : valid2;
    wire        o_last  = (sel == 0) ? last0 : last2;
    wire [31:0] o_word  = (sel == 0) ? word0 : word2;
    wire [8:0]  o_ones  = (sel == 0) ? ones0 : ones2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-derived table words: 0 = const 0, 1 = x0, 2 = (x==FF), 3 = x7.
    function automatic logic [31:0] exp_word(input int fs, input int k);
        case (fs)
            0:       return 32'h0000_0000;
            1:       return 32'hAAAA_AAAA;
            2:       return (k == 7) ? 32'h8000_0000 : 32'h0000_0000;
            default: return (k >= 4) ? 32'hFFFF_FFFF : 32'h0000_0000;
        endcase
    endfunction

    task automatic run(input int fs, input bit bp, input int exp_lat, input int exp_ones,
                       input bit b2b);
        int cnt;
        int k;
        int stall;
        int guard;
        fsel = fs;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        check($sformatf("f%0d first_x", fs), 64'(o_x), 64'h0);
        check($sformatf("f%0d busy_sweep", fs), 64'(o_busy), 64'h1);
        while (!o_valid && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check($sformatf("f%0d latency", fs), 64'(cnt), 64'(exp_lat));
        check($sformatf("f%0d ones_cnt", fs), 64'(o_ones), 64'(exp_ones));
        k = 0;
        stall = 0;
        guard = 0;
        while (k < 8 && guard < 100) begin
            guard++;
            check($sformatf("f%0d valid k%0d", fs, k), 64'(o_valid), 64'h1);
            check($sformatf("f%0d word k%0d", fs, k), 64'(o_word), 64'(exp_word(fs, k)));
            check($sformatf("f%0d last k%0d", fs, k), 64'(o_last), 64'(k == 7));
            if (bp && k == 3 && stall < 5) begin
                ready = 1'b0;
                stall++;
            end else begin
                ready = 1'b1;
                k++;
            end
            @(negedge clk);
        end
        ready = 1'b1;
        check($sformatf("f%0d words_delivered", fs), 64'(k), 64'd8);
        if (bp) check($sformatf("f%0d stall_cycles", fs), 64'(stall), 64'd5);
        check($sformatf("f%0d done_pulse", fs), 64'(o_done), 64'h1);
        check($sformatf("f%0d valid_after", fs), 64'(o_valid), 64'h0);
        check($sformatf("f%0d busy_after", fs), 64'(o_busy), 64'h0);
        if (b2b) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("f%0d start_in_done_ignored", fs), 64'(o_busy), 64'h0);
            check($sformatf("f%0d x_held_idle", fs), 64'(o_x), 64'hFF);
            check($sformatf("f%0d ones_held_idle", fs), 64'(o_ones), 64'(exp_ones));
        end else begin
            @(negedge clk);
            check($sformatf("f%0d done_one_cycle", fs), 64'(o_done), 64'h0);
        end
    endtask

    initial begin
        int g;
        bit saw;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst x0", 64'(x0), 64'h0);
        check("rst busy0", 64'(busy0), 64'h0);
        check("rst done0", 64'(done0), 64'h0);
        check("rst valid0", 64'(valid0), 64'h0);
        check("rst last0", 64'(last0), 64'h0);
        check("rst word0", 64'(word0), 64'h0);
        check("rst ones0", 64'(ones0), 64'h0);
        check("rst busy2", 64'(busy2), 64'h0);
        check("rst ones2", 64'(ones2), 64'h0);

        sel = 0;
        run(0, 1'b0, 257, 0, 1'b1);
        run(1, 1'b1, 257, 128, 1'b0);
        run(2, 1'b0, 257, 1, 1'b0);

        // Abort mid-sweep, then confirm a clean rerun.
        fsel = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (x0 != 8'h40 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("abort reach_x40", 64'(x0), 64'h40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(busy0), 64'h0);
        check("abort ones", 64'(ones0), 64'h0);
        check("abort x", 64'(x0), 64'h0);
        check("abort valid", 64'(valid0), 64'h0);
        saw = 1'b0;
        repeat (300) begin
            if (done0 || busy0) saw = 1'b1;
            @(negedge clk);
        end
        check("abort no_done", 64'(saw), 64'h0);
        run(1, 1'b0, 257, 128, 1'b0);

        sel = 1;
        run(3, 1'b0, 259, 128, 1'b0);
        run(3, 1'b1, 259, 128, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
